ahb3lite_wait_sram: RTL and testbench
=====================================

// Module: ahb3lite_wait_sram
// PURPOSE
//  AHB3-Lite slave memory with programmable wait states and error responses. It sits
//  directly downstream of one ahb3lite_interconnect slave port (slv_* bus), whose HREADYOUT
//  drives this block's HREADY. It is the bench/target memory behind each slave port.
//  It exercises interconnect stall, error and back-to-back paths.
// PARAMETERS
//  HADDR_SIZE   16    address width
//  HDATA_SIZE   32    data width (32 or 64); BE = HDATA_SIZE/8 byte lanes
//  MEM_DEPTH    1024  words of HDATA_SIZE; power of 2
//  WAIT_STATES  0     HREADYOUT-low cycles inserted per OKAY transfer (0..15)
// PORTS
//  HCLK       in   1           clock; all logic on rising edge
//  HRESET     in   1           reset, synchronous, active-high
//  HSEL       in   1           slave select
//  HADDR      in   HADDR_SIZE  address
//  HWDATA     in   HDATA_SIZE  write data (data phase)
//  HRDATA     out  HDATA_SIZE  read data (data phase)
//  HWRITE     in   1           1 = write
//  HSIZE      in   3           transfer size
//  HBURST     in   3           burst type (ignored; each beat handled independently)
//  HPROT      in   4           protection (ignored)
//  HTRANS     in   2           IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  HMASTLOCK  in   1           lock (ignored)
//  HREADY     in   1           bus ready (from interconnect HREADYOUT)
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0 = OKAY, 1 = ERROR
// BEHAVIOUR
//  - Address phase accepted when HSEL & HREADY & HTRANS[1]. IDLE/BUSY or !HSEL: next
//    cycle is zero-wait OKAY, no memory access.
//  - Error check at acceptance. ERROR if HSIZE > log2(BE), or HADDR not aligned to
//    HSIZE, or word index HADDR>>log2(BE) >= MEM_DEPTH.
//  - FSM states: IDLE, WAIT, ERR1, ERR2.
//    - IDLE: HREADYOUT=1, HRESP=0.
//      - accepted OK & WAIT_STATES>0 -> WAIT (counter=WAIT_STATES-1).
//      - accepted OK & WAIT_STATES==0 -> IDLE; the data phase completes next cycle.
//      - accepted error -> ERR1.
//    - WAIT: HREADYOUT=0, HRESP=0. Counter decrements. At 0 -> IDLE; that cycle's
//      successor is the data-phase completion cycle (HREADYOUT=1).
//    - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
//    - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new address phase may be accepted in ERR2
//      (HREADY high); it is handled as from IDLE.
//  - Latency: OKAY transfer data phase lasts WAIT_STATES+1 cycles. ERROR lasts exactly 2.
//  - Write commit happens on the data-phase cycle with HREADYOUT=1. Byte lanes are
//    little-endian and selected by HSIZE and HADDR[log2(BE)-1:0]; unselected bytes are
//    unchanged. Errored writes never modify memory.
//  - Read: HRDATA holds the full addressed word during the completing cycle. A write
//    data phase followed immediately by a read of the same word returns the merged new
//    bytes (forwarding). In all other cycles HRDATA holds its last value.
//  - Reset: HRESET forces IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, and clears the pending
//    address-phase register. Memory contents are NOT cleared. An in-flight write is
//    discarded, and reset mid-WAIT/ERR1 aborts with no commit.
//  - Wait counter width is $clog2(16). WAIT_STATES==0 must synthesise without the counter path.
// TESTING
//  1 WAIT_STATES=0; write word 0x0000_0010<=0xDEADBEEF, then read 0x0010 back-to-back
//    -> HRDATA=0xDEADBEEF on the read completion cycle (forwarding path), HRESP=0.
//  2 WAIT_STATES=3; read 0x0040 -> HREADYOUT low exactly 3 cycles, then high with data.
//    Address phase of the next NONSEQ is held until completion.
//  3 Byte writes 0x11,0x22 to 0x0021,0x0023 over word 0xAABBCCDD at 0x0020 -> read
//    returns 0x22BB11DD.
//  4 Halfword at 0x0001 (misaligned), word at index MEM_DEPTH (0x1000), and HSIZE=3 on a
//    32-bit bus -> each returns HRESP=1 with HREADYOUT 0 then 1; memory unchanged on readback.
//  5 BUSY and IDLE between SEQ beats of an INCR4 -> zero-wait OKAY, no memory access.
//    Beats complete with normal waits.
//  6 Assert HRESET during WAIT of a write to 0x0080 (old 0x12345678) -> next cycle
//    HREADYOUT=1, HRESP=0, HRDATA=0. Readback of 0x0080 = 0x12345678.

Source files
------------

// File: rtl/ahb3lite_wait_sram.sv
// AHB3-Lite slave SRAM with a fixed number of wait states per OKAY transfer
// and a two-cycle ERROR response for bad size, alignment or range.
//
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] while
// the slave is able to take one (IDLE or ERR2). The data phase of that
// transfer ends on the first cycle HREADYOUT is high; writes commit and reads
// present HRDATA on that cycle. While HREADYOUT is low the master holds both
// HWDATA and the next address phase.
module ahb3lite_wait_sram #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BE       = HDATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(BE);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int WIDX_W   = HADDR_SIZE - ADDR_LSB;
  localparam int CNT_W    = $clog2(16);

  localparam logic [2:0]         MAX_SIZE  = 3'(ADDR_LSB);
  localparam logic [WIDX_W:0]    DEPTH_LIM = (WIDX_W + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Storage; deliberately not reset.
  logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_write_q, pend_write_d;
  logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
  logic [BE-1:0]         pend_be_q, pend_be_d;
  logic [HDATA_SIZE-1:0] hrdata_q, hrdata_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;

  logic                  req_accept;
  logic                  req_err;
  logic                  req_misalign;
  logic                  req_oor;
  logic [IDX_W-1:0]      req_idx;
  logic [BE-1:0]         req_be;
  int                    req_off;
  int                    req_bytes;
  logic                  complete;
  logic                  commit;
  logic [HDATA_SIZE-1:0] fwd_word;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Decode the address phase on the bus: acceptance, error and byte lanes.
  always_comb begin
    req_off      = int'(HADDR[ADDR_LSB-1:0]);
    req_bytes    = 1 << HSIZE;
    req_misalign = 1'b0;
    for (int i = 0; i < ADDR_LSB; i++) begin
      if ((i < int'(HSIZE)) && HADDR[i]) req_misalign = 1'b1;
    end
    for (int i = 0; i < BE; i++) begin
      req_be[i] = (i >= req_off) && (i < req_off + req_bytes);
    end
    req_oor    = {1'b0, HADDR[HADDR_SIZE-1:ADDR_LSB]} >= DEPTH_LIM;
    req_err    = (HSIZE > MAX_SIZE) || req_misalign || req_oor;
    req_idx    = HADDR[ADDR_LSB +: IDX_W];
    req_accept = HSEL && HREADY && HTRANS[1] &&
                 ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    // An accepted OKAY transfer finishes on the first IDLE cycle after it.
    complete   = (state_q == ST_IDLE) && pend_valid_q;
    commit     = complete && pend_write_q;
  end

  // Read word for a zero-wait read, merging a write committing on this edge.
  always_comb begin
    fwd_word = mem_q[req_idx];
    if (commit && (pend_idx_q == req_idx)) begin
      for (int b = 0; b < BE; b++) begin
        if (pend_be_q[b]) fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // Next state, pending transfer, read data and response outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_write_d = pend_write_q;
    pend_idx_d   = pend_idx_q;
    pend_be_d    = pend_be_q;
    hrdata_d     = hrdata_q;
    if (complete) pend_valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (req_accept) begin
          if (req_err) begin
            state_d      = ST_ERR1;
            pend_valid_d = 1'b0;
          end else begin
            pend_valid_d = 1'b1;
            pend_write_d = HWRITE;
            pend_idx_d   = req_idx;
            pend_be_d    = req_be;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_INIT;
            end else if (!HWRITE) begin
              hrdata_d = fwd_word;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (!pend_write_q) hrdata_d = mem_q[pend_idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // Control FSM and registered bus outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_be_q    <= '0;
      hrdata_q     <= '0;
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      pend_idx_q   <= pend_idx_d;
      pend_be_q    <= pend_be_d;
      hrdata_q     <= hrdata_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
    end
  end

  // Wait counter exists only when wait states are configured.
  generate
    if (WAIT_STATES > 0) begin : g_wait_cnt
      always_ff @(posedge HCLK) begin
        if (HRESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end else begin : g_no_wait_cnt
      logic unused_cnt;
      assign unused_cnt = ^cnt_d;
      assign cnt_q      = '0;
    end
  endgenerate

  // Byte-lane write on the completing data-phase cycle; reset drops it.
  always_ff @(posedge HCLK) begin
    if (commit && !HRESET) begin
      for (int b = 0; b < BE; b++) begin
        if (pend_be_q[b]) mem_q[pend_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_wait_sram.sv
// Bench for ahb3lite_wait_sram: a zero-wait instance driven from a per-cycle
// vector table, and a three-wait instance exercised by hand-written sequences.
module tb_ahb3lite_wait_sram;

  localparam logic [1:0] TR_IDLE = 2'd0;
  localparam logic [1:0] TR_BUSY = 2'd1;
  localparam logic [1:0] TR_NS   = 2'd2;
  localparam logic [1:0] TR_SEQ  = 2'd3;
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  typedef struct {
    logic [1:0]  trans;
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic        exp_resp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic        sel3;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hsel0, hsel3, hready;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, resp0, resp3;

  int total;
  int bad;
  int lows;
  vec_t tbl[$];

  assign hsel0  = hsel & ~sel3;
  assign hsel3  = hsel & sel3;
  assign hready = sel3 ? ready3 : ready0;

  // Clock and watchdog.
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  ahb3lite_wait_sram #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ready0),
    .HRESP(resp0)
  );

  ahb3lite_wait_sram #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ready3),
    .HRESP(resp3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic drive(input logic [1:0] tr, input logic [15:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] wd);
    hsel   = 1'b1;
    htrans = tr;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    hwdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  // Counts HREADYOUT-low cycles of the current data phase; returns at the
  // falling edge of the completing cycle (or after the bound expires).
  task automatic count_wait(output int n);
    n = 0;
    @(negedge hclk);
    while (!hready && n <= 16) begin
      n++;
      next_cycle();
      @(negedge hclk);
    end
  endtask

  function automatic vec_t v(input logic [1:0] tr, input logic [15:0] a, input logic w,
                             input logic [2:0] sz, input logic [31:0] wd, input logic rdy,
                             input logic rsp, input logic ck, input logic [31:0] ex);
    vec_t r;
    r.trans = tr; r.addr = a; r.wr = w; r.size = sz; r.wdata = wd;
    r.exp_rdy = rdy; r.exp_resp = rsp; r.chk_rd = ck; r.exp_rd = ex;
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    lows  = 0;

    // Zero-wait instance: forwarding, byte lanes, errors, BUSY/IDLE in a burst.
    tbl.push_back(v(TR_NS,   16'h0010, 1, SZ_W, 32'h0,        1, 0, 1, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0010, 0, SZ_W, 32'hDEADBEEF, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0,        1, 0, 1, 32'hDEADBEEF));
    tbl.push_back(v(TR_NS,   16'h0020, 1, SZ_W, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0021, 1, SZ_B, 32'hAABBCCDD, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0023, 1, SZ_B, 32'h00001100, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0020, 0, SZ_W, 32'h22000000, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0,        1, 0, 1, 32'h22BB11DD));
    tbl.push_back(v(TR_NS,   16'h0020, 0, SZ_W, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0,        1, 0, 1, 32'h22BB11DD));
    tbl.push_back(v(TR_NS,   16'h0000, 1, SZ_W, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0001, 1, SZ_H, 32'hCAFEF00D, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0000FFFF, 0, 1, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0,        1, 1, 1, 32'h22BB11DD));
    tbl.push_back(v(TR_NS,   16'h1000, 1, SZ_W, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'hFFFFFFFF, 0, 1, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0000, 1, SZ_D, 32'h0,        1, 1, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'hFFFFFFFF, 0, 1, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0000, 0, SZ_W, 32'h0,        1, 1, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0,        1, 0, 1, 32'hCAFEF00D));
    tbl.push_back(v(TR_NS,   16'h0040, 1, SZ_W, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0044, 1, SZ_W, 32'h40404040, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0030, 1, SZ_W, 32'h44444444, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_BUSY, 16'h0040, 1, SZ_W, 32'hA0A0A0A0, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_SEQ,  16'h0034, 1, SZ_W, 32'h0BAD0BAD, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_IDLE, 16'h0044, 1, SZ_W, 32'hA1A1A1A1, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_SEQ,  16'h0038, 1, SZ_W, 32'h0BAD0BAD, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_SEQ,  16'h003C, 1, SZ_W, 32'hA2A2A2A2, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_NS,   16'h0030, 0, SZ_W, 32'hA3A3A3A3, 1, 0, 0, 32'h0));
    tbl.push_back(v(TR_SEQ,  16'h0034, 0, SZ_W, 32'h0,        1, 0, 1, 32'hA0A0A0A0));
    tbl.push_back(v(TR_SEQ,  16'h0038, 0, SZ_W, 32'h0,        1, 0, 1, 32'hA1A1A1A1));
    tbl.push_back(v(TR_SEQ,  16'h003C, 0, SZ_W, 32'h0,        1, 0, 1, 32'hA2A2A2A2));
    tbl.push_back(v(TR_NS,   16'h0040, 0, SZ_W, 32'h0,        1, 0, 1, 32'hA3A3A3A3));
    tbl.push_back(v(TR_NS,   16'h0044, 0, SZ_W, 32'h0,        1, 0, 1, 32'h40404040));
    tbl.push_back(v(TR_IDLE, 16'h0000, 0, SZ_W, 32'h0,        1, 0, 1, 32'h44444444));

    // Reset both instances.
    sel3 = 1'b0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;
    hreset = 1'b1;
    drive(TR_IDLE, 16'h0, 1'b0, SZ_W, 32'h0);
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check1("rst_ready0", ready0, 1'b1);
    check1("rst_resp0", resp0, 1'b0);
    check("rst_rdata0", rdata0, 32'h0);
    check1("rst_ready3", ready3, 1'b1);
    check1("rst_resp3", resp3, 1'b0);
    check("rst_rdata3", rdata3, 32'h0);
    next_cycle();

    // Apply the zero-wait vector table.
    foreach (tbl[i]) begin
      drive(tbl[i].trans, tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].wdata);
      @(negedge hclk);
      check1($sformatf("t%0d_ready", i), ready0, tbl[i].exp_rdy);
      check1($sformatf("t%0d_resp", i), resp0, tbl[i].exp_resp);
      if (tbl[i].chk_rd) check($sformatf("t%0d_rdata", i), rdata0, tbl[i].exp_rd);
      next_cycle();
    end

    // Three-wait instance: write then two reads with the next address held.
    sel3 = 1'b1;
    drive(TR_NS, 16'h0040, 1'b1, SZ_W, 32'h0);
    @(negedge hclk);
    check1("ws3_addr_ready", ready3, 1'b1);
    next_cycle();
    drive(TR_NS, 16'h0040, 1'b0, SZ_W, 32'h0BADCAFE);
    count_wait(lows);
    check("ws3_wr_waits", 32'(lows), 32'd3);
    check1("ws3_wr_resp", resp3, 1'b0);
    next_cycle();
    drive(TR_NS, 16'h0040, 1'b0, SZ_W, 32'h0);
    count_wait(lows);
    check("ws3_rd1_waits", 32'(lows), 32'd3);
    check("ws3_rd1_rdata", rdata3, 32'h0BADCAFE);
    check1("ws3_rd1_resp", resp3, 1'b0);
    next_cycle();
    drive(TR_IDLE, 16'h0, 1'b0, SZ_W, 32'h0);
    count_wait(lows);
    check("ws3_rd2_waits", 32'(lows), 32'd3);
    check("ws3_rd2_rdata", rdata3, 32'h0BADCAFE);
    next_cycle();
    @(negedge hclk);
    check1("ws3_idle_ready", ready3, 1'b1);
    check("ws3_idle_hold", rdata3, 32'h0BADCAFE);
    next_cycle();

    // Three-wait instance: BUSY then IDLE around burst beats.
    hburst = 3'b011;
    drive(TR_NS, 16'h0050, 1'b1, SZ_W, 32'h0);
    next_cycle();
    drive(TR_BUSY, 16'h0054, 1'b1, SZ_W, 32'h50505050);
    count_wait(lows);
    check("b_beat0_waits", 32'(lows), 32'd3);
    next_cycle();
    drive(TR_SEQ, 16'h0054, 1'b1, SZ_W, 32'hFFFF0000);
    @(negedge hclk);
    check1("b_busy_ready", ready3, 1'b1);
    check1("b_busy_resp", resp3, 1'b0);
    next_cycle();
    drive(TR_IDLE, 16'h0058, 1'b1, SZ_W, 32'h54545454);
    count_wait(lows);
    check("b_beat1_waits", 32'(lows), 32'd3);
    next_cycle();
    hburst = 3'd0;
    drive(TR_NS, 16'h0050, 1'b0, SZ_W, 32'h0);
    @(negedge hclk);
    check1("b_idle_ready", ready3, 1'b1);
    next_cycle();
    drive(TR_NS, 16'h0054, 1'b0, SZ_W, 32'h0);
    count_wait(lows);
    check("b_rd0_waits", 32'(lows), 32'd3);
    check("b_rd0_rdata", rdata3, 32'h50505050);
    next_cycle();
    drive(TR_IDLE, 16'h0, 1'b0, SZ_W, 32'h0);
    count_wait(lows);
    check("b_rd1_waits", 32'(lows), 32'd3);
    check("b_rd1_rdata", rdata3, 32'h54545454);
    next_cycle();

    // Three-wait instance: reset in the middle of a write's wait states.
    drive(TR_NS, 16'h0080, 1'b1, SZ_W, 32'h0);
    next_cycle();
    drive(TR_IDLE, 16'h0, 1'b0, SZ_W, 32'h12345678);
    count_wait(lows);
    check("r_init_waits", 32'(lows), 32'd3);
    next_cycle();
    drive(TR_NS, 16'h0080, 1'b1, SZ_W, 32'h0);
    next_cycle();
    drive(TR_IDLE, 16'h0, 1'b0, SZ_W, 32'hFFFFFFFF);
    @(negedge hclk);
    check1("r_in_wait", ready3, 1'b0);
    next_cycle();
    hreset = 1'b1;
    next_cycle();
    hreset = 1'b0;
    @(negedge hclk);
    check1("r_after_ready", ready3, 1'b1);
    check1("r_after_resp", resp3, 1'b0);
    check("r_after_rdata", rdata3, 32'h0);
    next_cycle();
    drive(TR_NS, 16'h0080, 1'b0, SZ_W, 32'h0);
    next_cycle();
    drive(TR_IDLE, 16'h0, 1'b0, SZ_W, 32'h0);
    count_wait(lows);
    check("r_rb_waits", 32'(lows), 32'd3);
    check("r_rb_rdata", rdata3, 32'h12345678);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
